// File: rtl/demux_1ton_hs_if.sv
// Handshake bundle for demux_1ton_hs.
//   s_valid/s_ready/s_data/s_sel : single producer side
//   m_valid/m_ready/m_data       : N_OUT consumer channels, channel k at [k*DATA_W +: DATA_W]
//   err_drop/drop_cnt            : out-of-range select reporting
// Modports: slave = demux side, master = producer/consumer (environment) side.
interface demux_1ton_hs_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SEL_W  = 1,
    parameter int unsigned CNT_W  = 8
);
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_W-1:0]       s_data;
    logic [SEL_W-1:0]        s_sel;
    logic [N_OUT-1:0]        m_valid;
    logic [N_OUT-1:0]        m_ready;
    logic [N_OUT*DATA_W-1:0] m_data;
    logic                    err_drop;
    logic [CNT_W-1:0]        drop_cnt;

    modport slave (
        input  s_valid, s_data, s_sel, m_ready,
        output s_ready, m_valid, m_data, err_drop, drop_cnt
    );

    modport master (
        output s_valid, s_data, s_sel, m_ready,
        input  s_ready, m_valid, m_data, err_drop, drop_cnt
    );
endinterface

// File: rtl/demux_1ton_hs.sv
// Registered 1-to-N demultiplexer with valid/ready handshake on every port.
// A 2-entry in-order buffer (head + skid) gives full throughput with a registered s_ready.
// Each transfer carries its own select; selects >= N_OUT are accepted, discarded and counted.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : demux_1ton_hs_if.slave (producer handshake, N_OUT channel outputs, drop reporting)
module demux_1ton_hs #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SEL_W  = 1,
    parameter int unsigned CNT_W  = 8
) (
    input logic            clk,
    input logic            rst,
    demux_1ton_hs_if.slave bus
);
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [DATA_W-1:0]       data0_q, data0_d, data1_q, data1_d;  // entry 0 is always the head
    logic [SEL_W-1:0]        sel0_q, sel0_d, sel1_q, sel1_d;
    logic                    s_ready_q;
    logic                    err_drop_q;
    logic [CNT_W-1:0]        drop_cnt_q;

    logic                    accept;
    logic                    in_range;
    logic                    push;
    logic                    emit;
    logic [N_OUT-1:0]        m_valid;
    logic [N_OUT*DATA_W-1:0] m_data;

    // Loop compare avoids width issues when N_OUT is not a power of two.
    always_comb begin
        in_range = 1'b0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (bus.s_sel == SEL_W'(k)) in_range = 1'b1;
        end
    end

    assign accept = bus.s_valid & s_ready_q;
    assign push   = accept & in_range;

    // Head drives only its own channel; every other channel is zero-gated.
    always_comb begin
        m_valid = '0;
        m_data  = '0;
        emit    = 1'b0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (state_q != StEmpty && sel0_q == SEL_W'(k)) begin
                m_valid[k]                  = 1'b1;
                m_data[k*DATA_W +: DATA_W]  = data0_q;
                emit                        = bus.m_ready[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data0_d = data0_q;
        sel0_d  = sel0_q;
        data1_d = data1_q;
        sel1_d  = sel1_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    data0_d = bus.s_data;
                    sel0_d  = bus.s_sel;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && emit) begin
                    data0_d = bus.s_data;
                    sel0_d  = bus.s_sel;
                end else if (push) begin
                    data1_d = bus.s_data;
                    sel1_d  = bus.s_sel;
                    state_d = StTwo;
                end else if (emit) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // s_ready is low here, so only an emit can happen.
                if (emit) begin
                    data0_d = data1_q;
                    sel0_d  = sel1_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            data0_q    <= '0;
            sel0_q     <= '0;
            data1_q    <= '0;
            sel1_q     <= '0;
            s_ready_q  <= 1'b1;
            err_drop_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            data0_q    <= data0_d;
            sel0_q     <= sel0_d;
            data1_q    <= data1_d;
            sel1_q     <= sel1_d;
            s_ready_q  <= (state_d != StTwo);
            err_drop_q <= accept & ~in_range;
            if (accept && !in_range && drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.m_valid  = m_valid;
    assign bus.m_data   = m_data;
    assign bus.err_drop = err_drop_q;
    assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_demux_1ton_hs.sv
module tb_demux_1ton_hs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    demux_1ton_hs_if #(.DATA_W(64), .N_OUT(2), .SEL_W(1), .CNT_W(8)) bus ();
    demux_1ton_hs_if #(.DATA_W(64), .N_OUT(3), .SEL_W(2), .CNT_W(2)) bus3 ();

    demux_1ton_hs #(.DATA_W(64), .N_OUT(2), .SEL_W(1), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    demux_1ton_hs #(.DATA_W(64), .N_OUT(3), .SEL_W(2), .CNT_W(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.s_valid  = 1'b0; bus.s_data  = '0; bus.s_sel  = '0; bus.m_ready  = '0;
        bus3.s_valid = 1'b0; bus3.s_data = '0; bus3.s_sel = '0; bus3.m_ready = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (bus.s_ready !== 1'b1) begin fails++;
            $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
        tests++; if (bus.m_valid !== 2'b00) begin fails++;
            $display("FAIL reset_m_valid got %b want 00", bus.m_valid); end
        tests++; if (bus.m_data !== 128'd0) begin fails++;
            $display("FAIL reset_m_data got %h want 0", bus.m_data); end
        tests++; if (bus.err_drop !== 1'b0) begin fails++;
            $display("FAIL reset_err_drop got %b want 0", bus.err_drop); end
        tests++; if (bus.drop_cnt !== 8'd0) begin fails++;
            $display("FAIL reset_drop_cnt got %0d want 0", bus.drop_cnt); end
        tests++; if (bus3.m_valid !== 3'b000 || bus3.drop_cnt !== 2'd0) begin fails++;
            $display("FAIL reset_dut3 got m_valid=%b cnt=%0d want 000/0",
                     bus3.m_valid, bus3.drop_cnt); end
    endtask

    task automatic test_single();
        bus.m_ready = 2'b11;
        bus.s_valid = 1'b1; bus.s_sel = 1'b1; bus.s_data = 64'hA5A5;
        step();
        bus.s_valid = 1'b0;
        tests++; if (bus.m_valid !== 2'b10) begin fails++;
            $display("FAIL single_m_valid got %b want 10", bus.m_valid); end
        tests++; if (bus.m_data[127:64] !== 64'hA5A5) begin fails++;
            $display("FAIL single_ch1_data got %h want a5a5", bus.m_data[127:64]); end
        tests++; if (bus.m_data[63:0] !== 64'd0) begin fails++;
            $display("FAIL single_ch0_zero got %h want 0", bus.m_data[63:0]); end
        step();
        tests++; if (bus.m_valid !== 2'b00) begin fails++;
            $display("FAIL single_drained got %b want 00", bus.m_valid); end
    endtask

    task automatic test_stream();
        logic [1:0] exp_v;
        bus.m_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_sel   = 1'(i % 2);
            bus.s_data  = 64'h100 + 64'(i);
            step();
            exp_v = (i % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (bus.m_valid !== exp_v ||
                         bus.m_data[(i % 2)*64 +: 64] !== 64'h100 + 64'(i)) begin fails++;
                $display("FAIL stream_word%0d got v=%b d=%h want v=%b d=%h", i, bus.m_valid,
                         bus.m_data[(i % 2)*64 +: 64], exp_v, 64'h100 + 64'(i)); end
            tests++; if (bus.s_ready !== 1'b1) begin fails++;
                $display("FAIL stream_ready%0d got %b want 1", i, bus.s_ready); end
        end
        bus.s_valid = 1'b0;
        step();
        tests++; if (bus.m_valid !== 2'b00) begin fails++;
            $display("FAIL stream_end got %b want 00", bus.m_valid); end
    endtask

    task automatic test_backpressure();
        bus.m_ready = 2'b00;
        bus.s_valid = 1'b1; bus.s_sel = 1'b0; bus.s_data = 64'hB0;
        step();
        tests++; if (bus.s_ready !== 1'b1) begin fails++;
            $display("FAIL bp_ready_one got %b want 1", bus.s_ready); end
        bus.s_sel = 1'b1; bus.s_data = 64'hB1;
        step();
        tests++; if (bus.s_ready !== 1'b0) begin fails++;
            $display("FAIL bp_ready_two got %b want 0", bus.s_ready); end
        bus.s_sel = 1'b0; bus.s_data = 64'hB2;
        step();
        tests++; if (bus.s_ready !== 1'b0 || bus.m_valid !== 2'b01 ||
                     bus.m_data[63:0] !== 64'hB0) begin fails++;
            $display("FAIL bp_stall got r=%b v=%b d=%h want 0/01/b0",
                     bus.s_ready, bus.m_valid, bus.m_data[63:0]); end
        bus.m_ready = 2'b11;
        step();
        tests++; if (bus.m_valid !== 2'b10 || bus.m_data[127:64] !== 64'hB1 ||
                     bus.s_ready !== 1'b1) begin fails++;
            $display("FAIL bp_drain1 got v=%b d=%h r=%b want 10/b1/1",
                     bus.m_valid, bus.m_data[127:64], bus.s_ready); end
        step();
        bus.s_valid = 1'b0;
        tests++; if (bus.m_valid !== 2'b01 || bus.m_data[63:0] !== 64'hB2) begin fails++;
            $display("FAIL bp_drain2 got v=%b d=%h want 01/b2", bus.m_valid, bus.m_data[63:0]); end
        step();
        tests++; if (bus.m_valid !== 2'b00 || bus.s_ready !== 1'b1) begin fails++;
            $display("FAIL bp_empty got v=%b r=%b want 00/1", bus.m_valid, bus.s_ready); end
    endtask

    task automatic test_bad_sel();
        bus3.m_ready = 3'b111;
        bus3.s_valid = 1'b1; bus3.s_sel = 2'd3; bus3.s_data = 64'hDEAD;
        step();
        bus3.s_valid = 1'b0;
        tests++; if (bus3.err_drop !== 1'b1 || bus3.drop_cnt !== 2'd1 ||
                     bus3.m_valid !== 3'b000) begin fails++;
            $display("FAIL bad_first got e=%b c=%0d v=%b want 1/1/000",
                     bus3.err_drop, bus3.drop_cnt, bus3.m_valid); end
        step();
        tests++; if (bus3.err_drop !== 1'b0 || bus3.drop_cnt !== 2'd1) begin fails++;
            $display("FAIL bad_pulse_end got e=%b c=%0d want 0/1", bus3.err_drop, bus3.drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            bus3.s_valid = 1'b1;
            step();
            tests++; if (bus3.err_drop !== 1'b1 || bus3.drop_cnt !== ((i < 1) ? 2'd2 : 2'd3))
            begin fails++;
                $display("FAIL bad_b2b%0d got e=%b c=%0d want 1/%0d", i, bus3.err_drop,
                         bus3.drop_cnt, (i < 1) ? 2 : 3); end
        end
        bus3.s_sel = 2'd2; bus3.s_data = 64'hC2;
        step();
        bus3.s_valid = 1'b0;
        tests++; if (bus3.m_valid !== 3'b100 || bus3.m_data[191:128] !== 64'hC2 ||
                     bus3.m_data[127:0] !== 128'd0 || bus3.err_drop !== 1'b0 ||
                     bus3.drop_cnt !== 2'd3) begin fails++;
            $display("FAIL ch2_route got v=%b d=%h e=%b c=%0d want 100/c2/0/3", bus3.m_valid,
                     bus3.m_data[191:128], bus3.err_drop, bus3.drop_cnt); end
        step();
    endtask

    task automatic test_head_of_line();
        bus.m_ready = 2'b10;
        bus.s_valid = 1'b1; bus.s_sel = 1'b0; bus.s_data = 64'hD0;
        step();
        bus.s_sel = 1'b1; bus.s_data = 64'hD1;
        step();
        bus.s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (bus.m_valid !== 2'b01 || bus.m_data[63:0] !== 64'hD0 ||
                         bus.m_data[127:64] !== 64'd0) begin fails++;
                $display("FAIL hol_blocked%0d got v=%b d=%h want 01/d0", i, bus.m_valid,
                         bus.m_data); end
            step();
        end
        bus.m_ready = 2'b11;
        step();
        tests++; if (bus.m_valid !== 2'b10 || bus.m_data[127:64] !== 64'hD1) begin fails++;
            $display("FAIL hol_release got v=%b d=%h want 10/d1", bus.m_valid,
                     bus.m_data[127:64]); end
        step();
        tests++; if (bus.m_valid !== 2'b00) begin fails++;
            $display("FAIL hol_empty got %b want 00", bus.m_valid); end
    endtask

    task automatic test_reset_in_two();
        bus.m_ready = 2'b00;
        bus.s_valid = 1'b1; bus.s_sel = 1'b0; bus.s_data = 64'hE0;
        step();
        bus.s_sel = 1'b1; bus.s_data = 64'hE1;
        step();
        bus.s_valid = 1'b0;
        tests++; if (bus.s_ready !== 1'b0) begin fails++;
            $display("FAIL rst2_full got %b want 0", bus.s_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (bus.m_valid !== 2'b00 || bus.s_ready !== 1'b1 ||
                     bus.m_data !== 128'd0) begin fails++;
            $display("FAIL rst2_cleared got v=%b r=%b d=%h want 00/1/0", bus.m_valid,
                     bus.s_ready, bus.m_data); end
        tests++; if (bus3.drop_cnt !== 2'd0 || bus3.m_valid !== 3'b000) begin fails++;
            $display("FAIL rst2_dut3 got c=%0d v=%b want 0/000", bus3.drop_cnt, bus3.m_valid); end
        bus.m_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (bus.m_valid !== 2'b00) begin fails++;
                $display("FAIL rst2_stale%0d got %b want 00", i, bus.m_valid); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_bad_sel();
        test_head_of_line();
        test_reset_in_two();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
